// File: rtl/gpio_pkg.sv
// Shared register map and reset constants for the bus-mapped GPIO port.
package gpio_pkg;

  localparam int GPIO_ADDR_W = 3;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_OUT      = 3'd0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_DIR      = 3'd1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IN       = 3'd2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_ALT      = 3'd3;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IRQ_EN   = 3'd4;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IRQ_RISE = 3'd5;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_STAT     = 3'd6;

  // Every register bit resets to this value; replicated to the port width.
  localparam logic GPIO_RST_BIT = 1'b0;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage pad synchroniser followed by a history flop for rise/fall detection.
module gpio_sync_edge #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  import gpio_pkg::*;

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= {WIDTH{GPIO_RST_BIT}};
      prev <= {WIDTH{GPIO_RST_BIT}};
    end else begin
      chain[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/gpio_port_ctrl.sv
// Bus-mapped GPIO port: config registers, pad mux, registered read path and
// sticky edge interrupts with write-1-to-clear status.
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = GPIO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_sel,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [WIDTH-1:0]  bus_wdata,
  output logic [WIDTH-1:0]  bus_rdata,
  output logic              bus_rvalid,
  input  logic [WIDTH-1:0]  pad_in,
  output logic [WIDTH-1:0]  pad_out,
  output logic [WIDTH-1:0]  pad_oe,
  input  logic [WIDTH-1:0]  periph_out,
  input  logic [WIDTH-1:0]  periph_oe,
  output logic [WIDTH-1:0]  periph_in,
  output logic              irq
);

  localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{GPIO_RST_BIT}};

  logic [WIDTH-1:0] reg_out, reg_dir, reg_alt, reg_irq_en, reg_irq_rise, reg_stat;
  logic [WIDTH-1:0] pin_sync, pin_rise, pin_fall, edge_hit, stat_clr, rd_mux;
  logic             wr_en, rd_en;

  gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (pad_in),
    .sync (pin_sync),
    .rise (pin_rise),
    .fall (pin_fall)
  );

  assign wr_en    = bus_sel & bus_wr;
  assign rd_en    = bus_sel & bus_rd;
  assign edge_hit = (reg_irq_rise & pin_rise) | (~reg_irq_rise & pin_fall);
  assign stat_clr = (wr_en && bus_addr == ADDR_W'(GPIO_REG_STAT)) ? bus_wdata : RST_VAL;

  always_comb begin
    rd_mux = RST_VAL;
    case (bus_addr)
      ADDR_W'(GPIO_REG_OUT):      rd_mux = reg_out;
      ADDR_W'(GPIO_REG_DIR):      rd_mux = reg_dir;
      ADDR_W'(GPIO_REG_IN):       rd_mux = pin_sync;
      ADDR_W'(GPIO_REG_ALT):      rd_mux = reg_alt;
      ADDR_W'(GPIO_REG_IRQ_EN):   rd_mux = reg_irq_en;
      ADDR_W'(GPIO_REG_IRQ_RISE): rd_mux = reg_irq_rise;
      ADDR_W'(GPIO_REG_STAT):     rd_mux = reg_stat;
      default:                    rd_mux = RST_VAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_out      <= RST_VAL;
      reg_dir      <= RST_VAL;
      reg_alt      <= RST_VAL;
      reg_irq_en   <= RST_VAL;
      reg_irq_rise <= RST_VAL;
      reg_stat     <= RST_VAL;
      bus_rdata    <= RST_VAL;
      bus_rvalid   <= 1'b0;
    end else begin
      if (wr_en) begin
        case (bus_addr)
          ADDR_W'(GPIO_REG_OUT):      reg_out      <= bus_wdata;
          ADDR_W'(GPIO_REG_DIR):      reg_dir      <= bus_wdata;
          ADDR_W'(GPIO_REG_ALT):      reg_alt      <= bus_wdata;
          ADDR_W'(GPIO_REG_IRQ_EN):   reg_irq_en   <= bus_wdata;
          ADDR_W'(GPIO_REG_IRQ_RISE): reg_irq_rise <= bus_wdata;
          default: ;
        endcase
      end
      // Set has priority over a same-cycle clear; disabled pins never latch.
      reg_stat   <= (reg_stat & ~stat_clr) | (edge_hit & reg_irq_en);
      bus_rvalid <= rd_en;
      if (rd_en) bus_rdata <= rd_mux;
    end
  end

  assign pad_out   = (reg_alt & periph_out) | (~reg_alt & reg_out);
  assign pad_oe    = (reg_alt & periph_oe)  | (~reg_alt & reg_dir);
  assign periph_in = pin_sync;
  assign irq       = |(reg_stat & reg_irq_en);

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed bench for gpio_port_ctrl; read data is checked by a scoreboard monitor.
module tb_gpio_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel, bus_wr, bus_rd;
  logic [2:0]  bus_addr;
  logic [15:0] bus_wdata, bus_rdata;
  logic        bus_rvalid;
  logic [15:0] pad_in, pad_out, pad_oe, periph_out, periph_oe, periph_in;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  gpio_port_ctrl #(.WIDTH(16), .SYNC_STAGES(2), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_sel    (bus_sel),
    .bus_wr     (bus_wr),
    .bus_rd     (bus_rd),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .pad_in     (pad_in),
    .pad_out    (pad_out),
    .pad_oe     (pad_oe),
    .periph_out (periph_out),
    .periph_oe  (periph_oe),
    .periph_in  (periph_in),
    .irq        (irq)
  );

  // Monitor: every rvalid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (bus_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got %h with no read pending", bus_rdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus_rdata !== e) begin
          errors++;
          $display("FAIL rdata: got %h expected %h", bus_rdata, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All bus tasks start and end at a falling clock edge.
  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp);
    bus_sel = 1'b1; bus_rd = 1'b1; bus_addr = a;
    exp_q.push_back(exp);
    @(negedge clk);
    bus_sel = 1'b0; bus_rd = 1'b0;
    @(negedge clk);
    chk("rvalid_one_cycle", {15'd0, bus_rvalid}, 16'h0000);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; bus_sel = 0; bus_wr = 0; bus_rd = 0; bus_addr = 0; bus_wdata = 0;
    pad_in = 16'hFFFF; periph_out = 0; periph_oe = 0;
    idle(2);
    chk("rst_pad_oe", pad_oe, 16'h0000);
    chk("rst_pad_out", pad_out, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    chk("rst_rvalid", {15'd0, bus_rvalid}, 16'h0000);
    rst = 1'b0;
    idle(2);
    bus_read(3'd2, 16'hFFFF);
    pad_in = 16'h0000;
    idle(4);
    wait_drain();

    bus_write(3'd1, 16'h00FF);
    bus_write(3'd0, 16'hA5A5);
    chk("dir_pad_oe", pad_oe, 16'h00FF);
    chk("out_pad_out", pad_out, 16'hA5A5);
    bus_read(3'd0, 16'hA5A5);
    bus_read(3'd1, 16'h00FF);

    periph_out = 16'h0002; periph_oe = 16'h0003;
    bus_write(3'd3, 16'h0003);
    chk("alt_pad_out", pad_out, 16'hA5A6);
    chk("alt_pad_oe", pad_oe, 16'h00FF);
    periph_oe = 16'h0001;
    #1;
    chk("alt_pad_oe_partial", pad_oe, 16'h00FD);
    bus_read(3'd3, 16'h0003);

    bus_write(3'd4, 16'h0001);
    bus_write(3'd5, 16'h0001);
    bus_read(3'd5, 16'h0001);
    pad_in[0] = 1'b1;
    idle(2);
    chk("irq_not_early", {15'd0, irq}, 16'h0000);
    idle(1);
    chk("irq_rise_latency", {15'd0, irq}, 16'h0001);
    bus_read(3'd6, 16'h0001);
    bus_read(3'd6, 16'h0001);

    pad_in[1] = 1'b1;
    idle(5);
    bus_read(3'd6, 16'h0001);
    bus_read(3'd2, 16'h0003);

    bus_write(3'd6, 16'h0001);
    chk("w1c_irq_drop", {15'd0, irq}, 16'h0000);
    bus_read(3'd6, 16'h0000);
    pad_in[0] = 1'b0;
    idle(5);
    bus_read(3'd6, 16'h0000);
    chk("fall_ignored_irq", {15'd0, irq}, 16'h0000);

    pad_in[0] = 1'b1;
    idle(5);
    chk("irq_rise_again", {15'd0, irq}, 16'h0001);
    pad_in[0] = 1'b0;
    idle(5);
    pad_in[0] = 1'b1;
    idle(2);
    bus_write(3'd6, 16'h0001);
    chk("collision_irq_held", {15'd0, irq}, 16'h0001);
    bus_read(3'd6, 16'h0001);

    bus_write(3'd4, 16'h0000);
    chk("mask_irq_low", {15'd0, irq}, 16'h0000);
    bus_read(3'd6, 16'h0001);
    bus_write(3'd4, 16'h0001);
    chk("unmask_irq_high", {15'd0, irq}, 16'h0001);
    bus_write(3'd6, 16'hFFFF);
    chk("clear_irq_low", {15'd0, irq}, 16'h0000);

    bus_write(3'd0, 16'h1234);
    bus_sel = 1; bus_wr = 1; bus_rd = 1; bus_addr = 3'd0; bus_wdata = 16'h5678;
    exp_q.push_back(16'h1234);
    @(negedge clk);
    bus_sel = 0; bus_wr = 0; bus_rd = 0;
    idle(1);
    bus_read(3'd0, 16'h5678);

    bus_write(3'd7, 16'hFFFF);
    bus_read(3'd7, 16'h0000);
    bus_write(3'd2, 16'hFFFF);
    bus_read(3'd2, 16'h0003);
    bus_sel = 0; bus_wr = 1; bus_addr = 3'd0; bus_wdata = 16'hFFFF;
    @(negedge clk);
    bus_wr = 0;
    bus_read(3'd0, 16'h5678);
    wait_drain();

    pad_in = 16'h0000;
    bus_write(3'd1, 16'hFFFF);
    bus_sel = 1; bus_rd = 1; bus_addr = 3'd0;
    @(posedge clk);
    #1;
    bus_sel = 0; bus_rd = 0;
    chk("pending_rvalid", {15'd0, bus_rvalid}, 16'h0001);
    rst = 1'b1;
    #1;
    chk("async_rst_pad_oe", pad_oe, 16'h0000);
    chk("async_rst_rvalid", {15'd0, bus_rvalid}, 16'h0000);
    chk("async_rst_pad_out", pad_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    for (int a = 0; a < 8; a++) bus_read(3'(a), 16'h0000);
    chk("post_rst_irq", {15'd0, irq}, 16'h0000);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_port_ctrl.md
Name: gpio_port_ctrl

Overview:
- Parametrised bus-mapped GPIO port; next generation of the fixed 16-bit GPIO_P0 port.
- Adds:
  - per-pin direction register
  - per-pin alternate-function (peripheral) select
  - metastability-safe input synchroniser
  - per-pin edge-detect interrupts with sticky write-1-to-clear status
- Sits between the CPU data bus and the pad tristate buffers. One instance per port.

Parameters:
- WIDTH, 16, number of pins; all data registers are WIDTH bits.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.
- ADDR_W, 3, register address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- bus_sel  in  1  port selected by address decode
- bus_wr  in  1  write strobe, qualified by bus_sel
- bus_rd  in  1  read strobe, qualified by bus_sel
- bus_addr  in  ADDR_W  register index
- bus_wdata  in  WIDTH  write data
- bus_rdata  out  WIDTH  registered read data
- bus_rvalid  out  1  one-cycle pulse when bus_rdata is valid
- pad_in  in  WIDTH  raw pad input, asynchronous to clk
- pad_out  out  WIDTH  drive value to pad tristate
- pad_oe  out  WIDTH  per-pin tristate enable; 1 = drive
- periph_out  in  WIDTH  alternate-function drive value
- periph_oe  in  WIDTH  alternate-function enable
- periph_in  out  WIDTH  synchronised pad value sent to peripherals
- irq  out  1  level interrupt to CPU

Behaviour:
- Register map by bus_addr:
  - 0 OUT: RW
  - 1 DIR: RW; 1 = output
  - 2 IN: RO; synchronised pins
  - 3 ALT: RW; 1 = peripheral owns pin
  - 4 IRQ_EN: RW
  - 5 IRQ_RISE: RW; 1 = rising edge, 0 = falling edge
  - 6 IRQ_STAT: read; write-1-to-clear
  - 7: reserved, reads 0
- Writes to IN and to 7 are ignored.
- Reset values, asynchronous: all registers 0; synchroniser and edge-history flops 0; bus_rdata 0; bus_rvalid 0; pad_oe 0 (all pins input); pad_out 0; irq 0.
- Pad mux, combinational, per bit i:
  - ALT[i]=1: pad_out = periph_out[i], pad_oe = periph_oe[i]
  - ALT[i]=0: pad_out = OUT[i], pad_oe = DIR[i]
- Synchroniser: SYNC_STAGES flop chain per bit. Output s drives IN and periph_in. A pad change is visible in s after SYNC_STAGES rising clk edges.
- Edge detect:
  - Flop p <= s each cycle.
  - rise = s & ~p; fall = ~s & p.
  - edge[i] = IRQ_RISE[i] ? rise[i] : fall[i].
- Status update each cycle: STAT <= (STAT & ~clr) | (edge & IRQ_EN).
  - clr = bus_wdata when a write to addr 6 occurs, else 0.
  - Set wins over a clear in the same cycle on the same bit.
  - Edges on pins whose IRQ_EN bit is 0 are discarded, not latched.
- irq = |(STAT & IRQ_EN), combinational from registers.
  - Clearing IRQ_EN masks irq but preserves already-latched STAT bits.
- Total latency from a pad edge to irq high: SYNC_STAGES+1 clk edges.
- Edge detection is independent of DIR and ALT. Output pins read back their own driven level and may raise interrupts.
- Bus read: when bus_sel & bus_rd is sampled at edge t:
  - bus_rdata loads the register value at edge t and bus_rvalid pulses high for that one cycle.
  - bus_rdata holds its value until the next read.
  - Read latency is 1 cycle.
- Simultaneous bus_rd and bus_wr to the same address: the read returns the pre-write value and the write takes effect.
- Reading IRQ_STAT has no side effect.
- bus_wr or bus_rd without bus_sel: no effect.
- Reset asserted mid-operation: everything returns to reset values immediately, pins tristate asynchronously, and any pending bus_rvalid is dropped.

Decomposition:
- Shared package gpio_pkg holds:
  - register index constants GPIO_REG_OUT=0 … GPIO_REG_STAT=6
  - GPIO_ADDR_W
  - the reset-value constant
- Sub-module gpio_sync_edge (parameters WIDTH, SYNC_STAGES) contains the synchroniser chain, the p flop and the rise/fall outputs.
- The top level holds the registers, pad mux, bus read path and irq.

Test Plan:
- Reset: rst=1 with pad_in=16'hFFFF → pad_oe=0, pad_out=0, irq=0, bus_rvalid=0. Release rst, read addr 2 → after SYNC_STAGES+1 cycles bus_rdata=16'hFFFF, bus_rvalid pulses for one cycle.
- Direction/output: write DIR=16'h00FF, OUT=16'hA5A5 → pad_oe=16'h00FF, pad_out=16'hA5A5. Read addr 0 → 16'hA5A5.
- Alternate function: ALT=16'h0003, periph_out=16'h0002, periph_oe=16'h0003 → pad_out[1:0]=2'b10, pad_oe[1:0]=2'b11; bits 15:2 still follow OUT/DIR.
- Interrupt:
  - IRQ_EN=16'h0001, IRQ_RISE=16'h0001; drive pad_in[0] 0→1 → irq high exactly 3 cycles later (SYNC_STAGES=2); STAT reads 16'h0001.
  - Same edge on pin 1 (not enabled) → STAT bit 1 stays 0.
  - Falling edge on pin 0 with IRQ_RISE[0]=1 → no set.
- W1C collision:
  - Write STAT=16'h0001 → irq drops the next cycle.
  - Repeat with a new rising edge landing in the same cycle as the clear → STAT[0] stays 1, irq stays high.
- Read/write same cycle to addr 0 (old 16'h1234, new 16'h5678) → bus_rdata=16'h1234, subsequent read returns 16'h5678. Assert rst mid-sequence → pad_oe=0 within the same cycle, all registers read 0 afterwards.
